// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-operated vending controller.
// Coin codes double as the change_type encoding.
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_VEND,
      ST_CHANGE
   } vend_state_t;

   localparam logic [1:0] COIN_N   = 2'b00;
   localparam logic [1:0] COIN_D   = 2'b01;
   localparam logic [1:0] COIN_Q   = 2'b10;
   localparam logic [1:0] COIN_BAD = 2'b11;

   localparam int unsigned VAL_N = 5;
   localparam int unsigned VAL_D = 10;
   localparam int unsigned VAL_Q = 25;

   function automatic int unsigned coin_value(input logic [1:0] t);
      unique case (t)
         COIN_N:  return VAL_N;
         COIN_D:  return VAL_D;
         COIN_Q:  return VAL_Q;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/vending_ctrl_timeout.sv
// Idle-cycle counter for the COLLECT state; expired marks the
// TIMEOUT-th consecutive idle cycle.
module vend_timeout_counter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/vending_ctrl.sv
// Vending machine controller: coin collection, one-cycle vend and
// greedy change / refund, all outputs decoded from registered state.
module vending_ctrl #(
   parameter int unsigned PRICE    = 50,
   parameter int unsigned CREDIT_W = 8,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                coin_valid,
   input  logic [1:0]          coin_type,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic                change_valid,
   output logic [1:0]          change_type,
   output logic                coin_reject,
   output logic                busy
);

   import vending_pkg::*;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   vend_state_t         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                rej_q, rej_d;
   logic [CREDIT_W-1:0] sum;
   logic [CREDIT_W-1:0] chg_val;
   logic [1:0]          chg_type;
   logic                coin_ok;
   logic                t_clear, t_en, t_exp;

   vend_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (t_clear),
      .enable (t_en),
      .expired(t_exp)
   );

   assign coin_ok = coin_valid && (coin_type != COIN_BAD);
   assign sum     = credit_q + CREDIT_W'(coin_value(coin_type));

   // Greedy choice of the next change coin
   always_comb begin
      chg_type = COIN_N;
      chg_val  = CREDIT_W'(VAL_N);
      if (credit_q >= CREDIT_W'(VAL_Q)) begin
         chg_type = COIN_Q;
         chg_val  = CREDIT_W'(VAL_Q);
      end else if (credit_q >= CREDIT_W'(VAL_D)) begin
         chg_type = COIN_D;
         chg_val  = CREDIT_W'(VAL_D);
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      rej_d    = 1'b0;
      t_clear  = (state_q != ST_COLLECT);
      t_en     = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (state_q == ST_COLLECT && cancel) begin
               state_d = ST_CHANGE;
               rej_d   = coin_valid;
            end else if (coin_ok) begin
               credit_d = sum;
               t_clear  = 1'b1;
               state_d  = (sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
            end else begin
               rej_d = coin_valid;
               if (state_q == ST_COLLECT) begin
                  t_en = 1'b1;
                  if (t_exp) state_d = ST_CHANGE;
               end
            end
         end
         ST_VEND: begin
            rej_d    = coin_valid;
            credit_d = credit_q - PRICE_C;
            state_d  = (credit_q == PRICE_C) ? ST_IDLE : ST_CHANGE;
         end
         ST_CHANGE: begin
            rej_d    = coin_valid;
            credit_d = credit_q - chg_val;
            if (credit_q == chg_val) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         credit_q <= '0;
         rej_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         rej_q    <= rej_d;
      end
   end

   assign credit       = credit_q;
   assign dispense     = (state_q == ST_VEND);
   assign change_valid = (state_q == ST_CHANGE);
   assign change_type  = change_valid ? chg_type : COIN_N;
   assign coin_reject  = rej_q;
   assign busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: a transaction-level model schedules
// expected pulses and change coins; a negedge monitor matches them.
module tb_vending_ctrl;

   localparam int PRICE = 50;
   localparam int CW    = 8;
   localparam int TO    = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          coin_valid;
   logic [1:0]    coin_type;
   logic          cancel;
   logic [CW-1:0] credit;
   logic          dispense;
   logic          change_valid;
   logic [1:0]    change_type;
   logic          coin_reject;
   logic          busy;

   vending_ctrl #(.PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .coin_valid  (coin_valid),
      .coin_type   (coin_type),
      .cancel      (cancel),
      .credit      (credit),
      .dispense    (dispense),
      .change_valid(change_valid),
      .change_type (change_type),
      .coin_reject (coin_reject),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int kind;
      int code;
      int cred;
   } ev_t;

   ev_t out_q[$];
   int  rej_q[$];
   int  nchk = 0;
   int  nerr = 0;
   int  m = 0;
   int  idle = 0;
   int  busy_until = -1;
   bit  mon_on = 1'b0;
   ev_t me;
   int  exp_c;

   function automatic void chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic int cval(input logic [1:0] t);
      return (t == 2'd0) ? 5 : (t == 2'd1) ? 10 : 25;
   endfunction

   task automatic plan_change(input int t0, input int amt, output int last);
      int c = t0;
      int a = amt;
      int v;
      last = t0 - 1;
      while (a > 0) begin
         v = (a >= 25) ? 25 : (a >= 10) ? 10 : 5;
         out_q.push_back('{c, 2, (v == 25) ? 2 : (v == 10) ? 1 : 0, a});
         a -= v;
         last = c;
         c++;
      end
   endtask

   task automatic model(input int k, input bit cv, input logic [1:0] ct, input bit can);
      int last;
      if (k <= busy_until) begin
         if (cv) rej_q.push_back(k + 1);
      end else if (can && m > 0) begin
         if (cv) rej_q.push_back(k + 1);
         plan_change(k + 1, m, busy_until);
         m = 0;
         idle = 0;
      end else if (cv && ct != 2'd3) begin
         m += cval(ct);
         idle = 0;
         if (m >= PRICE) begin
            out_q.push_back('{k + 1, 1, 0, m});
            busy_until = k + 1;
            plan_change(k + 2, m - PRICE, last);
            if (m > PRICE) busy_until = last;
            m = 0;
         end
      end else begin
         if (cv) rej_q.push_back(k + 1);
         if (m > 0) begin
            idle++;
            if (idle == TO) begin
               plan_change(k + 1, m, busy_until);
               m = 0;
               idle = 0;
            end
         end
      end
   endtask

   task automatic step(input bit cv, input logic [1:0] ct, input bit can);
      coin_valid = cv;
      coin_type  = ct;
      cancel     = can;
      model(cyc, cv, ct, can);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (cyc <= busy_until + 1 && n < 64) begin
         step(1'b0, 2'd0, 1'b0);
         n++;
      end
      chk("drain_bound", n, (n < 64) ? n : -1);
      chk("drain_credit", int'(credit), m);
   endtask

   always @(negedge clk) begin
      if (mon_on && rstn) begin
         while (rej_q.size() > 0 && rej_q[0] < cyc)
            chk("reject_missed", cyc, rej_q.pop_front());
         if (coin_reject) begin
            exp_c = (rej_q.size() > 0) ? rej_q.pop_front() : -1;
            chk("reject_cycle", cyc, exp_c);
         end
         while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
            me = out_q.pop_front();
            chk((me.kind == 1) ? "dispense_missed" : "change_missed", cyc, me.cyc);
         end
         if (dispense || change_valid) begin
            if (out_q.size() > 0) me = out_q.pop_front();
            else me = '{-1, 0, 0, 0};
            chk("out_cycle", cyc, me.cyc);
            chk("out_kind", dispense ? 1 : 2, me.kind);
            if (me.kind == 2) chk("change_type", int'(change_type), me.code);
            chk("out_credit", int'(credit), me.cred);
            chk("out_busy", int'(busy), 1);
         end
         if (!change_valid) chk("change_type_idle", int'(change_type), 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn       = 1'b0;
      coin_valid = 1'b0;
      coin_type  = 2'd0;
      cancel     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_credit", int'(credit), 0);
      chk("rst_dispense", int'(dispense), 0);
      chk("rst_change_valid", int'(change_valid), 0);
      chk("rst_change_type", int'(change_type), 0);
      chk("rst_coin_reject", int'(coin_reject), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;
      mon_on = 1'b1;

      // two quarters: exact price
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd2, 1'b0);
      chk("qq_dispense", int'(dispense), 1);
      chk("qq_credit_vend", int'(credit), 50);
      step(1'b0, 2'd0, 1'b0);
      chk("qq_no_change", int'(change_valid), 0);
      chk("qq_credit", int'(credit), 0);
      chk("qq_busy", int'(busy), 0);

      // 70 cents: two dimes change
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd2, 1'b0);
      chk("c70_dispense", int'(dispense), 1);
      step(1'b0, 2'd0, 1'b0);
      chk("c70_chg1_type", int'(change_type), 1);
      chk("c70_chg1_credit", int'(credit), 20);
      step(1'b0, 2'd0, 1'b0);
      chk("c70_chg2_type", int'(change_type), 1);
      chk("c70_chg2_credit", int'(credit), 10);
      step(1'b0, 2'd0, 1'b0);
      chk("c70_done_valid", int'(change_valid), 0);
      chk("c70_done_credit", int'(credit), 0);

      // cancel refund of 35
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      step(1'b0, 2'd0, 1'b1);
      chk("can_dispense", int'(dispense), 0);
      chk("can_chg1_type", int'(change_type), 2);
      chk("can_chg1_credit", int'(credit), 35);
      step(1'b0, 2'd0, 1'b0);
      chk("can_chg2_type", int'(change_type), 1);
      chk("can_chg2_credit", int'(credit), 10);
      step(1'b0, 2'd0, 1'b0);
      chk("can_done_credit", int'(credit), 0);

      // timeout refund of a nickel
      step(1'b1, 2'd0, 1'b0);
      repeat (TO - 1) step(1'b0, 2'd0, 1'b0);
      chk("tmo_early", int'(change_valid), 0);
      step(1'b0, 2'd0, 1'b0);
      chk("tmo_valid", int'(change_valid), 1);
      chk("tmo_type", int'(change_type), 0);
      chk("tmo_credit", int'(credit), 5);
      drain();

      // invalid coin, then a quarter during change
      step(1'b1, 2'd3, 1'b0);
      chk("bad_reject", int'(coin_reject), 1);
      chk("bad_credit", int'(credit), 0);
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      step(1'b0, 2'd0, 1'b1);
      step(1'b1, 2'd2, 1'b0);
      chk("busy_reject", int'(coin_reject), 1);
      chk("busy_credit", int'(credit), 10);
      drain();

      // reset in the middle of change
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd2, 1'b0);
      step(1'b0, 2'd0, 1'b0);
      chk("mid_credit", int'(credit), 20);
      rstn = 1'b0;
      #1;
      out_q.delete();
      rej_q.delete();
      m = 0;
      idle = 0;
      busy_until = -1;
      chk("mrst_credit", int'(credit), 0);
      chk("mrst_change_valid", int'(change_valid), 0);
      chk("mrst_change_type", int'(change_type), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_dispense", int'(dispense), 0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step(1'b0, 2'd0, 1'b0);
      chk("post_rst_credit", int'(credit), 0);
      chk("post_rst_busy", int'(busy), 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) repeat (TO + 2) step(1'b0, 2'd0, 1'b0);
         step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 15) == 0);
      end
      drain();
      step(1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd0, 1'b0);
      chk("scoreboard_empty", out_q.size() + rej_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
